// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one registered ALU between NUM_REQ requesters.
// Optional feature macro: ALU_ARB_OPCOUNT_EN adds the op_count completed-operation counter.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [5*NUM_REQ-1:0]   req_sel,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [4:0]             alu_sel,
    input  logic [31:0]            alu_out,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [31:0]            resp_data,
    output logic                   resp_zero,
    output logic                   resp_err,
    output logic                   busy
`ifdef ALU_ARB_OPCOUNT_EN
    ,
    output logic [31:0]            op_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam int         CNT_W  = 3;
    localparam int         IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err_q;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [4:0]       r_alu_sel;
    logic [ID_W-1:0]  r_resp_id;
    logic [31:0]      r_resp_data;
    logic             r_resp_zero;
    logic             r_resp_err;

    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_cand;
    logic [31:0]      w_win_a;
    logic [31:0]      w_win_b;
    logic [4:0]       w_win_sel;
    logic             w_accept;
    logic             w_resp_hs;

    // Search starts one past the last grant and wraps, so every waiting requester is reached.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_win_a   = req_a[32*w_win +: 32];
        w_win_b   = req_b[32*w_win +: 32];
        w_win_sel = req_sel[5*w_win +: 5];
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            req_ready[w_win] = 1'b1;
        end
    end

    assign w_accept  = (r_state == S_IDLE) && w_found;
    assign w_resp_hs = (r_state == S_RESP) && resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_err_q      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_resp_zero  <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_a      <= w_win_a;
                        r_alu_b      <= w_win_b;
                        r_alu_sel    <= w_win_sel;
                        r_resp_id    <= ID_W'(w_win);
                        r_last_grant <= w_win;
                        r_err_q      <= (w_win_sel == OP_DIV) && (w_win_b == '0);
                        r_cnt        <= CNT_W'(ALU_LAT);
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Counter hits zero one edge after the ALU's own latency has elapsed.
                    if (r_cnt == '0) begin
                        r_resp_data <= alu_out;
                        r_resp_zero <= (alu_out == '0);
                        r_resp_err  <= r_err_q;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_resp_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_OPCOUNT_EN
    logic [31:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_resp_hs) begin
            r_op_count <= r_op_count + 32'd1;
        end
    end

    assign op_count = r_op_count;
`else
    // Counter omitted: no extra state in this build.
`endif

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign resp_valid = (r_state == S_RESP);
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_zero  = r_resp_zero;
    assign resp_err   = r_resp_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a one-cycle registered ALU stand-in.
module tb_alu_arbiter;

    localparam int NR = 4;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [32*NR-1:0] req_a;
    logic [32*NR-1:0] req_b;
    logic [5*NR-1:0]  req_sel;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [4:0]       alu_sel;
    logic [31:0]      alu_out;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [31:0]      resp_data;
    logic             resp_zero;
    logic             resp_err;
    logic             busy;
`ifdef ALU_ARB_OPCOUNT_EN
    logic [31:0]      op_count;
`endif

    alu_arbiter #(.NUM_REQ(NR), .ID_W(2), .ALU_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err),
        .busy       (busy)
`ifdef ALU_ARB_OPCOUNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU: add, sub, mul, div (divide by zero returns all ones).
    always @(posedge clk) begin
        case (alu_sel)
            5'b00000: alu_out <= alu_a + alu_b;
            5'b00001: alu_out <= alu_a - alu_b;
            5'b00010: alu_out <= alu_a * alu_b;
            5'b00011: alu_out <= (alu_b == 0) ? 32'hFFFF_FFFF : alu_a / alu_b;
            default:  alu_out <= alu_a & alu_b;
        endcase
    end

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] data, input logic err);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.zero = (data == 32'd0);
        e.err  = err;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got id %0d data %h, expected no response", resp_id, resp_data);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_id",   32'(resp_id),   32'(mon_e.id));
                chk("resp_data", resp_data,      mon_e.data);
                chk("resp_zero", 32'(resp_zero), 32'(mon_e.zero));
                chk("resp_err",  32'(resp_err),  32'(mon_e.err));
            end
        end
    end

    task automatic wait_ready(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_timeout: requester %0d got no grant, expected grant within 20 cycles", id);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy stayed %0b, expected 0 within 40 cycles", busy);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sel, input logic [31:0] exp_data, input logic exp_err);
        bit ok;
        @(posedge clk); #1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_sel[5*id +: 5] = sel;
        req_valid          = '0;
        req_valid[id]      = 1'b1;
        resp_ready         = 1'b1;
        push_exp(id, exp_data, exp_err);
        wait_ready(id, ok);
        if (ok) chk("issue_onehot", 32'(req_ready), 32'(1 << id));
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1);
    end

    initial begin
        bit ok;
        int prev_cyc;
        int exp_g;

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_sel    = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_busy",       32'(busy),       0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_zero",  32'(resp_zero),  0);
        chk("rst_resp_err",   32'(resp_err),   0);
        chk("rst_resp_id",    32'(resp_id),    0);
        chk("rst_resp_data",  resp_data,       0);
        chk("rst_alu_a",      alu_a,           0);
        chk("rst_alu_b",      alu_b,           0);
        chk("rst_alu_sel",    32'(alu_sel),    0);
        chk("rst_req_ready",  32'(req_ready),  0);

        // Single add with exact latency checks
        @(posedge clk); #1;
        req_a[31:0]  = 32'd5;
        req_b[31:0]  = 32'd7;
        req_sel[4:0] = 5'b00000;
        req_valid    = 4'b0001;
        resp_ready   = 1'b1;
        push_exp(0, 32'd12, 1'b0);
        @(negedge clk);
        chk("add_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("add_alu_a",      alu_a,           5);
        chk("add_alu_b",      alu_b,           7);
        chk("add_alu_sel",    32'(alu_sel),    0);
        chk("add_busy",       32'(busy),       1);
        chk("add_wait_ready", 32'(req_ready),  0);
        chk("add_valid_e0",   32'(resp_valid), 0);
        @(negedge clk);
        chk("add_valid_e1",   32'(resp_valid), 0);
        @(negedge clk);
        chk("add_valid_e2",   32'(resp_valid), 1);
        @(negedge clk);
        chk("add_valid_done", 32'(resp_valid), 0);
        chk("add_busy_done",  32'(busy),       0);
        chk("add_alu_hold",   alu_a,           5);

        // Round-robin with all requesters continuously valid
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            req_a[32*i +: 32] = 32'(i);
            req_b[32*i +: 32] = 32'd1;
            req_sel[5*i +: 5] = 5'b00000;
        end
        for (int k = 0; k < 5; k++) push_exp(k % NR, 32'((k % NR) + 1), 1'b0);
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        prev_cyc   = 0;
        for (int k = 0; k < 5; k++) begin
            exp_g = k % NR;
            wait_ready(exp_g, ok);
            chk("rr_grant", 32'(req_ready), 32'(1 << exp_g));
            if (k > 0) chk("rr_interval", 32'(cyc - prev_cyc), 32'd4);
            prev_cyc = cyc;
            @(posedge clk); #1;
            if (k == 4) req_valid = '0;
        end
        wait_idle();

        // Backpressure with requester 1 waiting
        do_reset();
        @(posedge clk); #1;
        req_a[31:0]   = 32'd2;
        req_b[31:0]   = 32'd3;
        req_sel[4:0]  = 5'b00010;
        req_a[63:32]  = 32'd20;
        req_b[63:32]  = 32'd5;
        req_sel[9:5]  = 5'b00001;
        resp_ready    = 1'b0;
        req_valid     = 4'b0011;
        push_exp(0, 32'd6, 1'b0);
        push_exp(1, 32'd15, 1'b0);
        @(negedge clk);
        chk("bp_ready0", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_valid_seen", 32'(ok), 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid_hold", 32'(resp_valid), 1);
            chk("bp_data_hold",  resp_data,       6);
            chk("bp_id_hold",    32'(resp_id),    0);
            chk("bp_no_ready",   32'(req_ready),  0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Zero flag and divide cases
        issue(2, 32'd9,  32'd9, 5'b00001, 32'd0,         1'b0);
        issue(3, 32'd10, 32'd0, 5'b00011, 32'hFFFF_FFFF, 1'b1);
        issue(1, 32'd10, 32'd3, 5'b00011, 32'd3,         1'b0);

        // Reset during WAIT abandons the op and restores requester 0 priority
        @(posedge clk); #1;
        req_a[95:64]   = 32'd4;
        req_b[95:64]   = 32'd4;
        req_sel[14:10] = 5'b00000;
        req_valid      = 4'b0100;
        resp_ready     = 1'b1;
        wait_ready(2, ok);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b0;
        req_a[31:0]  = 32'd1;
        req_b[31:0]  = 32'd1;
        req_sel[4:0] = 5'b00000;
        req_valid    = 4'b0101;
        push_exp(0, 32'd2, 1'b0);
        @(negedge clk);
        chk("mid_busy_rst",  32'(busy),       0);
        chk("mid_valid_rst", 32'(resp_valid), 0);
        chk("mid_grant0",    32'(req_ready),  32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

`ifdef ALU_ARB_OPCOUNT_EN
        do_reset();
        @(negedge clk);
        chk("opc_reset", op_count, 0);
        issue(0, 32'd1, 32'd2, 5'b00000, 32'd3, 1'b0);
        issue(1, 32'd8, 32'd2, 5'b00001, 32'd6, 1'b0);
        issue(2, 32'd4, 32'd4, 5'b00010, 32'd16, 1'b0);
        chk("opc_three", op_count, 3);
        @(posedge clk); #1;
        force dut.r_op_count = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.r_op_count;
        @(negedge clk);
        chk("opc_preload", op_count, 32'hFFFF_FFFF);
        issue(3, 32'd7, 32'd1, 5'b00000, 32'd8, 1'b0);
        chk("opc_wrap", op_count, 0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one registered 32-bit ALU (5-bit op select, result valid on the clock edge after inputs are sampled) between NUM_REQ requesters, e.g. neighbouring PEs in the CGRA fabric.
- Arbitrates round-robin and drives the ALU operand and select lines.
- Waits out the ALU latency, captures the result and returns it on a single response channel tagged with the requester ID.
- Sits between the PE issue logic and the alu instance; one operation in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of resp_id; must be at least clog2(NUM_REQ).
- ALU_LAT, 1, number of clock edges from ALU input sampling to a stable ALU_Out (1..4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  32*NUM_REQ  operand A, requester i at bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing as req_a.
- req_sel  in  5*NUM_REQ  ALU op select, requester i at bits [5i+4:5i].
- alu_a  out  32  to ALU input A.
- alu_b  out  32  to ALU input B.
- alu_sel  out  5  to ALU_Sel.
- alu_out  in  32  from ALU_Out.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_data  out  32  captured ALU result.
- resp_zero  out  1  high when resp_data == 0, computed locally.
- resp_err  out  1  high when the op was divide (5'b00011) with B == 0.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset values:
  - State is IDLE.
  - alu_a, alu_b and alu_sel are 0.
  - resp_valid, resp_zero, resp_err and busy are 0.
  - resp_id and resp_data are 0.
  - Round-robin pointer last_grant is NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation abandons the in-flight op with no response; the ALU result is ignored.
- Handshakes:
  - A request transfers on the edge where req_valid[i] && req_ready[i].
  - A response transfers on the edge where resp_valid && resp_ready.
  - A requester holds its payload stable while req_valid[i] is high.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching from last_grant+1 upward with wrap-around.
  - req_ready[winner] is asserted combinationally in the same cycle. All other ready bits are 0; all are 0 if no request is valid.
  - On the accept edge:
    - alu_a, alu_b and alu_sel load the winner's payload.
    - resp_id and last_grant load the winner index.
    - err_q loads (sel == 5'b00011 && b == 0).
    - wait counter loads ALU_LAT; next state is WAIT.
- WAIT:
  - req_ready is all 0; alu_* are held stable.
  - Counter decrements each edge.
  - On the edge where the counter equals 0:
    - resp_data loads alu_out.
    - resp_zero loads (alu_out == 0).
    - resp_err loads err_q.
    - Next state is RESP.
  - With ALU_LAT=1: accept at edge E0, ALU samples at E1, capture at E2, resp_valid high from E2. Total of ALU_LAT+1 edges after accept.
- RESP:
  - resp_valid is high; resp_* are held stable until the handshake edge.
  - On the handshake edge: resp_valid drops and next state is IDLE.
  - No new acceptance happens in the handshake cycle. Minimum issue interval is ALU_LAT+3 cycles.
- busy = (state != IDLE).
- alu_* keep their last values after an op completes.
- Requests that are not selected wait; there is no starvation. With all requesters continuously valid, grants go 0,1,2,3,0,...
- A requester that drops req_valid before being granted is skipped with no side effect.

Optional Feature:
- Macro: ALU_ARB_OPCOUNT_EN.
- Defined:
  - Adds output port op_count [31:0].
  - Reset value 0.
  - Increments by 1 on every response handshake edge and wraps from 32'hFFFFFFFF to 0.
  - Reset takes priority over increment.
- Undefined: the op_count port and its register do not exist; all other behaviour is identical.

Test Plan:
- Single add: after reset, req_valid[0]=1, a=5, b=7, sel=5'b00000, resp_ready=1 -> req_ready[0] high in the request cycle; alu_sel=0 after the accept edge; resp_valid 2 edges later with resp_data=12, resp_id=0, resp_zero=0, resp_err=0.
- Round-robin: all four requesters valid, each with sel=00000, a=i, b=1, resp_ready=1 -> grant order 0,1,2,3,0; resp_data values 1,2,3,4; issue interval exactly ALU_LAT+3 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid, requester 1 also valid -> resp_* stable and req_ready all 0 throughout; requester 1 granted in the first IDLE cycle after the handshake.
- Zero and divide-by-zero:
  - sub a=9, b=9 -> resp_data=0, resp_zero=1.
  - div a=10, b=0 -> resp_err=1, resp_data=32'hFFFFFFFF.
  - div a=10, b=3 -> resp_data=3, resp_err=0.
- Reset mid-op: assert rst during WAIT -> next cycle state IDLE, busy=0, resp_valid=0; next grant goes to requester 0 even if the interrupted requester was 2.
- With ALU_ARB_OPCOUNT_EN: 3 completed ops -> op_count=3; preload to 32'hFFFFFFFF via force, one op -> op_count=0.
